// File: rtl/benes_switch_stage_pkg.sv
// Shared types for the FHE ALU interconnect.
// Benes column state, lane vector type and default lane count.
package FHE_ALU_PKG;

  localparam int FSIZE = 64;
  localparam int BENES_STAGE_LANES_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } benes_state_t;

  typedef logic [BENES_STAGE_LANES_DEFAULT-1:0][FSIZE-1:0] lane_vec_t;

endpackage

// File: rtl/benes_switch_stage_delay.sv
// Fixed-depth register chain carrying {valid, last, data}.
// Cleared by synchronous active-high rst.
module benes_stage_delay #(
  parameter int W     = 64,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_last,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0]        v_q;
  logic [DEPTH-1:0]        l_q;
  logic [DEPTH-1:0][W-1:0] d_q;

  // shift valid, last and data together one stage per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      l_q <= '0;
      d_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      l_q[0] <= in_last;
      d_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_last  = l_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: rtl/benes_switch_stage.sv
// One column of 2x2 Benes switches, double-buffered config.
// Optional counters under BENES_STAGE_STATS_EN.
module benes_switch_stage
  import FHE_ALU_PKG::*;
#(
  parameter int DATA_SIZE  = FSIZE,
  parameter int LANES      = BENES_STAGE_LANES_DEFAULT,
  parameter int OUT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [LANES*DATA_SIZE-1:0] in_data,
  input  logic                       cfg_wr_en,
  input  logic [LANES/2-1:0]         cfg_wr_data,
  input  logic                       cfg_commit,
  output logic                       cfg_busy,
`ifdef BENES_STAGE_STATS_EN
  output logic [31:0]                stat_beats,
  output logic [15:0]                stat_frames,
  output logic [7:0]                 stat_cfg_applies,
`endif
  output logic                       out_valid,
  output logic                       out_last,
  output logic [LANES*DATA_SIZE-1:0] out_data
);

  localparam int NSW = LANES / 2;

  benes_state_t   state_q;
  logic [NSW-1:0] shadow_q;
  logic [NSW-1:0] active_q;
  logic           pending_q;
  logic           apply;

  logic [LANES-1:0][DATA_SIZE-1:0] in_v;
  logic [LANES-1:0][DATA_SIZE-1:0] sw_v;
  logic [LANES*DATA_SIZE-1:0]      stage_d;

  assign in_v = in_data;

  // apply at an idle gap or on the closing beat of a frame
  assign apply = pending_q &
                 ((state_q == IDLE & ~in_valid) |
                  (in_valid & in_last));

  // frame tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (in_valid) begin
      state_q <= in_last ? IDLE : FRAME;
    end
  end

  // shadow/active config and pending commit
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (cfg_wr_en)
        shadow_q <= cfg_wr_data;
      if (apply)
        active_q <= shadow_q;
      if (cfg_commit)
        pending_q <= 1'b1;
      else if (apply)
        pending_q <= 1'b0;
    end
  end

  assign cfg_busy = pending_q;

  // switch network, steered by the current active config
  always_comb begin
    sw_v = '0;
    for (int i = 0; i < NSW; i++) begin
      if (active_q[i]) begin
        sw_v[2*i]   = in_v[2*i+1];
        sw_v[2*i+1] = in_v[2*i];
      end else begin
        sw_v[2*i]   = in_v[2*i];
        sw_v[2*i+1] = in_v[2*i+1];
      end
    end
  end

  assign stage_d = in_valid ? sw_v : '0;

  benes_stage_delay #(
    .W     (LANES*DATA_SIZE),
    .DEPTH (OUT_CYCLES)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_valid & in_last),
    .in_data   (stage_d),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data)
  );

`ifdef BENES_STAGE_STATS_EN
  logic [31:0] beats_q;
  logic [15:0] frames_q;
  logic [7:0]  applies_q;

  // beat/frame counters wrap, apply counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q   <= '0;
      frames_q  <= '0;
      applies_q <= '0;
    end else begin
      if (in_valid)
        beats_q <= beats_q + 32'd1;
      if (in_valid & in_last)
        frames_q <= frames_q + 16'd1;
      if (apply & (applies_q != 8'hFF))
        applies_q <= applies_q + 8'd1;
    end
  end

  assign stat_beats       = beats_q;
  assign stat_frames      = frames_q;
  assign stat_cfg_applies = applies_q;
`endif

endmodule

// File: tb/tb_benes_switch_stage.sv
// Directed bench for benes_switch_stage (LANES=4, DATA_SIZE=8).
// Instances with OUT_CYCLES=1 and OUT_CYCLES=3 share stimulus.
module tb_benes_switch_stage;

  localparam int DS = 8;
  localparam int LN = 4;
  localparam int W  = LN * DS;

  localparam logic [W-1:0] A    = 32'h44332211;
  localparam logic [W-1:0] X0   = 32'h44331122;
  localparam logic [W-1:0] XALL = 32'h33441122;
  localparam logic [W-1:0] X1   = 32'h33442211;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_last;
  logic [W-1:0] in_data;
  logic         cfg_wr_en;
  logic [1:0]   cfg_wr_data;
  logic         cfg_commit;

  logic         busy1, busy3;
  logic         ov1, ov3, ol1, ol3;
  logic [W-1:0] od1, od3;
`ifdef BENES_STAGE_STATS_EN
  logic [31:0]  sb1, sb3;
  logic [15:0]  sf1, sf3;
  logic [7:0]   sa1, sa3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  benes_switch_stage #(
    .DATA_SIZE (DS), .LANES (LN), .OUT_CYCLES (1)
  ) u_dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_last (in_last), .in_data (in_data),
    .cfg_wr_en (cfg_wr_en), .cfg_wr_data (cfg_wr_data),
    .cfg_commit (cfg_commit), .cfg_busy (busy1),
`ifdef BENES_STAGE_STATS_EN
    .stat_beats (sb1), .stat_frames (sf1), .stat_cfg_applies (sa1),
`endif
    .out_valid (ov1), .out_last (ol1), .out_data (od1)
  );

  benes_switch_stage #(
    .DATA_SIZE (DS), .LANES (LN), .OUT_CYCLES (3)
  ) u_dut3 (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_last (in_last), .in_data (in_data),
    .cfg_wr_en (cfg_wr_en), .cfg_wr_data (cfg_wr_data),
    .cfg_commit (cfg_commit), .cfg_busy (busy3),
`ifdef BENES_STAGE_STATS_EN
    .stat_beats (sb3), .stat_frames (sf3), .stat_cfg_applies (sa3),
`endif
    .out_valid (ov3), .out_last (ol3), .out_data (od3)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic last, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_last  = last;
    in_data  = d;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cfg_wr_en   = 1'b0;
    cfg_wr_data = '0;
    cfg_commit  = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(ov1), 64'd0);
    chk("rst_last", 64'(ol1), 64'd0);
    chk("rst_data", 64'(od1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);

    // pass-through single-beat frame
    beat(1'b1, A);
    step();
    chk("pass_valid", 64'(ov1), 64'd1);
    chk("pass_last", 64'(ol1), 64'd1);
    chk("pass_data", 64'(od1), 64'(A));
    idle();
    step();
    chk("gap_valid", 64'(ov1), 64'd0);
    chk("gap_data", 64'(od1), 64'd0);

    // idle commit of 01
    cfg_wr_en   = 1'b1;
    cfg_wr_data = 2'b01;
    cfg_commit  = 1'b1;
    step();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    chk("idle_busy_hi", 64'(busy1), 64'd1);
    step();
    chk("idle_busy_lo", 64'(busy1), 64'd0);
    beat(1'b1, A);
    step();
    chk("x0_data", 64'(od1), 64'(X0));
    idle();
    step();

    // mid-frame commit of 11
    beat(1'b0, A);
    step();
    chk("mf_b1", 64'(od1), 64'(X0));
    beat(1'b0, A);
    cfg_wr_en   = 1'b1;
    cfg_wr_data = 2'b11;
    cfg_commit  = 1'b1;
    step();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    chk("mf_b2", 64'(od1), 64'(X0));
    chk("mf_busy2", 64'(busy1), 64'd1);
    beat(1'b0, A);
    step();
    chk("mf_b3", 64'(od1), 64'(X0));
    chk("mf_busy3", 64'(busy1), 64'd1);
    beat(1'b1, A);
    step();
    chk("mf_b4", 64'(od1), 64'(X0));
    chk("mf_b4_last", 64'(ol1), 64'd1);
    chk("mf_busy4", 64'(busy1), 64'd0);
    beat(1'b1, A);
    step();
    chk("mf_next", 64'(od1), 64'(XALL));
    idle();
    step();

    // write+commit, then rewrite before apply
    beat(1'b0, A);
    cfg_wr_en   = 1'b1;
    cfg_wr_data = 2'b01;
    cfg_commit  = 1'b1;
    step();
    cfg_commit  = 1'b0;
    cfg_wr_data = 2'b10;
    beat(1'b0, A);
    step();
    cfg_wr_en = 1'b0;
    chk("rw_busy", 64'(busy1), 64'd1);
    beat(1'b1, A);
    step();
    chk("rw_old", 64'(od1), 64'(XALL));
    chk("rw_busy_lo", 64'(busy1), 64'd0);
    beat(1'b1, A);
    step();
    chk("rw_new", 64'(od1), 64'(X1));
    idle();
    step();

    // in_last alone is ignored
    in_last = 1'b1;
    step();
    chk("lone_last_v", 64'(ov1), 64'd0);
    chk("lone_last_l", 64'(ol1), 64'd0);
    in_last = 1'b0;

    // reset mid-frame with beats in flight on the 3-deep stage
    beat(1'b0, A);
    step();
    beat(1'b0, A);
    cfg_wr_en   = 1'b1;
    cfg_wr_data = 2'b01;
    cfg_commit  = 1'b1;
    step();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r3_valid", 64'(ov3), 64'd0);
    chk("r3_data", 64'(od3), 64'd0);
    chk("r3_busy", 64'(busy3), 64'd0);
    chk("r1_busy", 64'(busy1), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r3_no_ghost", 64'(ov3), 64'd0);
    end
    beat(1'b1, A);
    step();
    idle();
    chk("r1_pass", 64'(od1), 64'(A));
    chk("r3_lat1", 64'(ov3), 64'd0);
    step();
    chk("r3_lat2", 64'(ov3), 64'd0);
    step();
    chk("r3_valid3", 64'(ov3), 64'd1);
    chk("r3_last3", 64'(ol3), 64'd1);
    chk("r3_pass", 64'(od3), 64'(A));
    step();
    chk("r3_drain", 64'(ov3), 64'd0);

`ifdef BENES_STAGE_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < ((f == 2) ? 4 : 3); b++) begin
        beat((f == 2) ? (b == 3) : (b == 2), A);
        step();
      end
    end
    idle();
    step();
    chk("st_beats", 64'(sb1), 64'd10);
    chk("st_frames", 64'(sf1), 64'd3);
    force u_dut.beats_q = 32'hFFFFFFFF;
    #1;
    release u_dut.beats_q;
    beat(1'b1, A);
    step();
    idle();
    chk("st_wrap", 64'(sb1), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
